hazard_scoreboard: RTL and testbench

//  Parametrised hazard unit for the pipelined core. Combines EX/MEM forwarding and load-use detection

---
 rtl/hazard_scoreboard_if.sv | 55 +++++
 rtl/hazard_scoreboard.sv | 133 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Bundle of ID/EX/MEM hazard inputs and hazard-unit outputs.
// master: the pipeline side (drives ID/EX/MEM info, reads the hazard results).
// slave : the hazard unit (reads pipeline info, drives stall/forward/writeback/perf).
// Handshake: there is no valid/ready pair here. id_valid qualifies the ID fields in
// the same cycle. stall works as the "not ready" response to that instruction: while
// stall = 1 the pipeline keeps ID unchanged and presents it again the next cycle.
// acc_issue means the accelerator op was accepted in this cycle.
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 3,
    parameter int LAT_W      = 4
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_en;
    logic                  id_rs2_en;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_acc_op;
    logic [LAT_W-1:0]      id_acc_lat;
    logic                  id_flush;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  ex_reg_write;
    logic                  mem_reg_write;
    logic                  ex_is_load;

    logic                  stall;
    logic [1:0]            forward_a;
    logic [1:0]            forward_b;
    logic                  acc_issue;
    logic                  acc_wb_valid;
    logic [REG_ADDR_W-1:0] acc_wb_rd;
    logic [NUM_REGS-1:0]   busy_vec;
    logic [31:0]           perf_stall_cnt;
    logic [31:0]           perf_lu_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_en, id_rs2_en, id_rd, id_reg_write,
               id_acc_op, id_acc_lat, id_flush, ex_rd, mem_rd, ex_reg_write,
               mem_reg_write, ex_is_load,
        input  stall, forward_a, forward_b, acc_issue, acc_wb_valid, acc_wb_rd,
               busy_vec, perf_stall_cnt, perf_lu_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_en, id_rs2_en, id_rd, id_reg_write,
               id_acc_op, id_acc_lat, id_flush, ex_rd, mem_rd, ex_reg_write,
               mem_reg_write, ex_is_load,
        output stall, forward_a, forward_b, acc_issue, acc_wb_valid, acc_wb_rd,
               busy_vec, perf_stall_cnt, perf_lu_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard unit: EX/MEM forwarding, load-use stall, and a per-register countdown
// scoreboard for variable-latency accelerator ops (several may be in flight).
// Ports:
//   clk   - core clock
//   rst_n - asynchronous active-low reset, clears all counters (pending writebacks dropped)
//   hif   - hazard_scoreboard_if.slave: ID/EX/MEM info in; stall, forward_a/b,
//           acc_issue, acc_wb_valid/rd, busy_vec, perf counters out
// Optional feature: define HAZARD_PERF_EN to build the 32-bit stall and load-use
// stall counters; otherwise both perf outputs are tied to 0.
// There is no FSM: the only state is the counter array (plus the optional perf counters).
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 3,
    parameter int LAT_W      = 4,
    parameter bit ZERO_REG   = 1'b1
) (
    input logic                clk,
    input logic                rst_n,
    hazard_scoreboard_if.slave hif
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [LAT_W-1:0]      cnt_q [NUM_REGS];
    logic [LAT_W-1:0]      cnt_d [NUM_REGS];

    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [LAT_W-1:0]      leff;
    logic [LAT_W:0]        leff_p1;
    logic                  slot_clash;
    logic                  rs1_live, rs2_live;
    logic                  load_use, raw, waw;
    logic                  stall, issue;
    logic [NUM_REGS-1:0]   busy;

    // First-match forwarding priority: EX, then MEM, then accelerator writeback.
    function automatic logic [1:0] fwd_sel(input logic live, input logic [REG_ADDR_W-1:0] rs,
                                           input logic ex_we, input logic [REG_ADDR_W-1:0] ex_rd,
                                           input logic mem_we, input logic [REG_ADDR_W-1:0] mem_rd,
                                           input logic acc_v, input logic [REG_ADDR_W-1:0] acc_rd);
        logic [1:0] sel;
        sel = 2'b00;
        if (live) begin
            if (ex_we && ex_rd == rs)        sel = 2'b10;
            else if (mem_we && mem_rd == rs) sel = 2'b01;
            else if (acc_v && acc_rd == rs)  sel = 2'b11;
        end
        return sel;
    endfunction

    always_comb begin
        wb_valid   = 1'b0;
        wb_rd      = '0;
        slot_clash = 1'b0;
        busy       = '0;
        leff       = (hif.id_acc_lat == '0) ? LAT_W'(1) : hif.id_acc_lat;
        // One extra bit so Leff+1 cannot wrap when Leff is the maximum latency.
        leff_p1    = {1'b0, leff} + (LAT_W+1)'(1);

        // The slot rule guarantees at most one counter sits at 1 in any cycle.
        for (int r = 0; r < NUM_REGS; r++) begin
            busy[r] = (cnt_q[r] != '0);
            if (cnt_q[r] == LAT_W'(1)) begin
                wb_valid = 1'b1;
                wb_rd    = REG_ADDR_W'(r);
            end
            if ({1'b0, cnt_q[r]} == leff_p1) slot_clash = 1'b1;
        end

        rs1_live = hif.id_rs1_en && !(ZERO_REG && hif.id_rs1 == '0);
        rs2_live = hif.id_rs2_en && !(ZERO_REG && hif.id_rs2 == '0);

        load_use = hif.ex_is_load && hif.ex_reg_write &&
                   ((rs1_live && hif.ex_rd == hif.id_rs1) || (rs2_live && hif.ex_rd == hif.id_rs2));
        // A count of exactly 1 is served by the writeback forward, so only >1 stalls.
        raw      = (rs1_live && cnt_q[hif.id_rs1] > LAT_W'(1)) ||
                   (rs2_live && cnt_q[hif.id_rs2] > LAT_W'(1));
        waw      = hif.id_reg_write && (cnt_q[hif.id_rd] != '0);

        stall = hif.id_valid && !hif.id_flush &&
                (load_use || raw || waw || (hif.id_acc_op && slot_clash));
        issue = hif.id_valid && hif.id_acc_op && !stall && !hif.id_flush;

        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
        end
        // WAW stalling ensures the loaded register is not the one counting down to 0 now.
        if (issue && !(ZERO_REG && hif.id_rd == '0)) cnt_d[hif.id_rd] = leff;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    assign hif.stall        = stall;
    assign hif.acc_issue    = issue;
    assign hif.acc_wb_valid = wb_valid;
    assign hif.acc_wb_rd    = wb_rd;
    assign hif.busy_vec     = busy;
    assign hif.forward_a    = fwd_sel(rs1_live, hif.id_rs1, hif.ex_reg_write, hif.ex_rd,
                                      hif.mem_reg_write, hif.mem_rd, wb_valid, wb_rd);
    assign hif.forward_b    = fwd_sel(rs2_live, hif.id_rs2, hif.ex_reg_write, hif.ex_rd,
                                      hif.mem_reg_write, hif.mem_rd, wb_valid, wb_rd);

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_lu_q, perf_lu_d;

    always_comb begin
        perf_stall_d = perf_stall_q + (stall ? 32'd1 : 32'd0);
        perf_lu_d    = perf_lu_q + ((stall && load_use) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_lu_q    <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_lu_q    <= perf_lu_d;
        end
    end

    assign hif.perf_stall_cnt = perf_stall_q;
    assign hif.perf_lu_cnt    = perf_lu_q;
`else
    assign hif.perf_stall_cnt = 32'd0;
    assign hif.perf_lu_cnt    = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    hazard_scoreboard_if #(.REG_ADDR_W(3), .LAT_W(4)) hif ();

    hazard_scoreboard #(.REG_ADDR_W(3), .LAT_W(4), .ZERO_REG(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (hif.slave)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic       valid, flush;
        logic [2:0] rs1;
        logic       rs1_en;
        logic [2:0] rs2;
        logic       rs2_en;
        logic [2:0] ex_rd;
        logic       ex_we, ex_load;
        logic [2:0] mem_rd;
        logic       mem_we;
        logic       exp_stall;
        logic [1:0] exp_fa, exp_fb;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(logic valid, logic flush, logic [2:0] rs1, logic rs1_en,
                                logic [2:0] rs2, logic rs2_en, logic [2:0] ex_rd, logic ex_we,
                                logic ex_load, logic [2:0] mem_rd, logic mem_we,
                                logic exp_stall, logic [1:0] exp_fa, logic [1:0] exp_fb);
        vec_t v;
        v.valid = valid; v.flush = flush; v.rs1 = rs1; v.rs1_en = rs1_en;
        v.rs2 = rs2; v.rs2_en = rs2_en; v.ex_rd = ex_rd; v.ex_we = ex_we;
        v.ex_load = ex_load; v.mem_rd = mem_rd; v.mem_we = mem_we;
        v.exp_stall = exp_stall; v.exp_fa = exp_fa; v.exp_fb = exp_fb;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle();
        hif.id_valid = 1'b1; hif.id_flush = 1'b0;
        hif.id_rs1 = 3'd0; hif.id_rs1_en = 1'b0; hif.id_rs2 = 3'd0; hif.id_rs2_en = 1'b0;
        hif.id_rd = 3'd0; hif.id_reg_write = 1'b0; hif.id_acc_op = 1'b0; hif.id_acc_lat = 4'd0;
        hif.ex_rd = 3'd0; hif.ex_reg_write = 1'b0; hif.ex_is_load = 1'b0;
        hif.mem_rd = 3'd0; hif.mem_reg_write = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue_acc(logic [2:0] rd, logic [3:0] lat);
        idle();
        hif.id_acc_op = 1'b1; hif.id_rd = rd; hif.id_reg_write = 1'b1; hif.id_acc_lat = lat;
    endtask

    task automatic reader(logic [2:0] rs);
        idle();
        hif.id_rs1 = rs; hif.id_rs1_en = 1'b1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        // ALU/load forwarding and stall cases with an empty scoreboard.
        vecs[0]  = mk(1,0, 3'd2,1, 3'd0,0, 3'd2,1,0, 3'd0,0, 0, 2'b10, 2'b00);
        vecs[1]  = mk(1,0, 3'd2,1, 3'd0,0, 3'd2,1,1, 3'd0,0, 1, 2'b10, 2'b00);
        vecs[2]  = mk(1,0, 3'd2,1, 3'd0,0, 3'd0,0,0, 3'd2,1, 0, 2'b01, 2'b00);
        vecs[3]  = mk(1,0, 3'd2,1, 3'd0,0, 3'd2,1,0, 3'd2,1, 0, 2'b10, 2'b00);
        vecs[4]  = mk(1,0, 3'd1,1, 3'd5,1, 3'd0,0,0, 3'd5,1, 0, 2'b00, 2'b01);
        vecs[5]  = mk(1,0, 3'd0,1, 3'd0,1, 3'd0,1,1, 3'd0,1, 0, 2'b00, 2'b00);
        vecs[6]  = mk(1,0, 3'd2,0, 3'd0,0, 3'd2,1,1, 3'd0,0, 0, 2'b00, 2'b00);
        vecs[7]  = mk(1,0, 3'd4,1, 3'd3,1, 3'd3,1,1, 3'd4,1, 1, 2'b01, 2'b10);
        vecs[8]  = mk(1,0, 3'd2,1, 3'd0,0, 3'd2,0,1, 3'd0,0, 0, 2'b00, 2'b00);
        vecs[9]  = mk(1,1, 3'd2,1, 3'd0,0, 3'd2,1,1, 3'd0,0, 0, 2'b10, 2'b00);
        vecs[10] = mk(0,0, 3'd6,0, 3'd6,1, 3'd6,1,1, 3'd0,0, 0, 2'b00, 2'b10);

        do_reset();
        @(negedge clk);
        chk("rst_busy_vec", 32'(hif.busy_vec), 32'd0);
        chk("rst_wb_valid", 32'(hif.acc_wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(hif.acc_wb_rd), 32'd0);
        chk("rst_perf_stall", hif.perf_stall_cnt, 32'd0);

        for (int i = 0; i < 11; i++) begin
            step();
            idle();
            hif.id_valid = vecs[i].valid; hif.id_flush = vecs[i].flush;
            hif.id_rs1 = vecs[i].rs1; hif.id_rs1_en = vecs[i].rs1_en;
            hif.id_rs2 = vecs[i].rs2; hif.id_rs2_en = vecs[i].rs2_en;
            hif.ex_rd = vecs[i].ex_rd; hif.ex_reg_write = vecs[i].ex_we;
            hif.ex_is_load = vecs[i].ex_load;
            hif.mem_rd = vecs[i].mem_rd; hif.mem_reg_write = vecs[i].mem_we;
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i), 32'(hif.stall), 32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_fwd_a", i), 32'(hif.forward_a), 32'(vecs[i].exp_fa));
            chk($sformatf("vec%0d_fwd_b", i), 32'(hif.forward_b), 32'(vecs[i].exp_fb));
        end

        // Load-use: one stall cycle, then the load sits in MEM and forwards with 01.
        step(); reader(3'd2); hif.ex_rd = 3'd2; hif.ex_reg_write = 1'b1; hif.ex_is_load = 1'b1;
        @(negedge clk);
        chk("lu_stall", 32'(hif.stall), 32'd1);
        step(); reader(3'd2); hif.mem_rd = 3'd2; hif.mem_reg_write = 1'b1;
        @(negedge clk);
        chk("lu_after_stall", 32'(hif.stall), 32'd0);
        chk("lu_after_fwd_a", 32'(hif.forward_a), 32'b01);

        // Acc op r3 lat 4: busy T+1..T+4, reader stalls T+1..T+3, forward 11 at T+4.
        step(); issue_acc(3'd3, 4'd4);
        @(negedge clk);
        chk("acc2_issue", 32'(hif.acc_issue), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            step(); reader(3'd3);
            @(negedge clk);
            chk($sformatf("acc2_raw_stall_t%0d", k), 32'(hif.stall), 32'd1);
            chk($sformatf("acc2_busy_t%0d", k), 32'(hif.busy_vec), 32'h08);
            chk($sformatf("acc2_nowb_t%0d", k), 32'(hif.acc_wb_valid), 32'd0);
        end
        step(); reader(3'd3);
        @(negedge clk);
        chk("acc2_wb_stall", 32'(hif.stall), 32'd0);
        chk("acc2_wb_fwd_a", 32'(hif.forward_a), 32'b11);
        chk("acc2_wb_valid", 32'(hif.acc_wb_valid), 32'd1);
        chk("acc2_wb_rd", 32'(hif.acc_wb_rd), 32'd3);
        chk("acc2_wb_busy", 32'(hif.busy_vec), 32'h08);
        step(); idle();
        @(negedge clk);
        chk("acc2_done_busy", 32'(hif.busy_vec), 32'd0);
        chk("acc2_done_wb", 32'(hif.acc_wb_valid), 32'd0);

        // WAW: ALU write to a register with an op in flight stalls.
        step(); issue_acc(3'd3, 4'd4);
        step(); idle(); hif.id_rd = 3'd3; hif.id_reg_write = 1'b1;
        @(negedge clk);
        chk("waw_stall", 32'(hif.stall), 32'd1);
        repeat (5) step();
        idle();

        // Slot clash: A lat5 at T, B lat4 at T+1 would both write back at T+5.
        step(); issue_acc(3'd1, 4'd5);
        step(); issue_acc(3'd2, 4'd4);
        @(negedge clk);
        chk("slot_stall", 32'(hif.stall), 32'd1);
        chk("slot_no_issue", 32'(hif.acc_issue), 32'd0);
        step(); idle();
        repeat (5) step();
        // B lat3 at T+1 issues and writes back at T+4, A at T+5.
        step(); issue_acc(3'd1, 4'd5);
        step(); issue_acc(3'd2, 4'd3);
        @(negedge clk);
        chk("slot_ok_issue", 32'(hif.acc_issue), 32'd1);
        step(); idle();
        step();
        step();
        @(negedge clk);
        chk("slot_b_wb_valid", 32'(hif.acc_wb_valid), 32'd1);
        chk("slot_b_wb_rd", 32'(hif.acc_wb_rd), 32'd2);
        step();
        @(negedge clk);
        chk("slot_a_wb_valid", 32'(hif.acc_wb_valid), 32'd1);
        chk("slot_a_wb_rd", 32'(hif.acc_wb_rd), 32'd1);
        step();

        // r0 destination/source: no forward, no stall, no counter loaded.
        step(); issue_acc(3'd0, 4'd0); hif.id_rs1_en = 1'b1;
        hif.ex_rd = 3'd0; hif.ex_reg_write = 1'b1; hif.ex_is_load = 1'b1;
        @(negedge clk);
        chk("r0_stall", 32'(hif.stall), 32'd0);
        chk("r0_fwd_a", 32'(hif.forward_a), 32'd0);
        step(); idle();
        @(negedge clk);
        chk("r0_busy", 32'(hif.busy_vec), 32'd0);
        chk("r0_no_wb", 32'(hif.acc_wb_valid), 32'd0);
        // lat 0 behaves as lat 1.
        step(); issue_acc(3'd4, 4'd0);
        @(negedge clk);
        chk("lat0_issue", 32'(hif.acc_issue), 32'd1);
        step(); idle();
        @(negedge clk);
        chk("lat0_wb_valid", 32'(hif.acc_wb_valid), 32'd1);
        chk("lat0_wb_rd", 32'(hif.acc_wb_rd), 32'd4);
        chk("lat0_busy", 32'(hif.busy_vec), 32'h10);
        step();
        @(negedge clk);
        chk("lat0_done", 32'(hif.busy_vec), 32'd0);

        // Flush suppresses stall and issue; in-flight op still writes back.
        step(); issue_acc(3'd6, 4'd3);
        step(); issue_acc(3'd7, 4'd2); hif.id_rs1 = 3'd6; hif.id_rs1_en = 1'b1; hif.id_flush = 1'b1;
        @(negedge clk);
        chk("flush_stall", 32'(hif.stall), 32'd0);
        chk("flush_issue", 32'(hif.acc_issue), 32'd0);
        step(); idle();
        step();
        @(negedge clk);
        chk("flush_wb_valid", 32'(hif.acc_wb_valid), 32'd1);
        chk("flush_wb_rd", 32'(hif.acc_wb_rd), 32'd6);
        step();
        @(negedge clk);
        chk("flush_done_busy", 32'(hif.busy_vec), 32'd0);

        // Reset mid-flight drops the pending writeback.
        step(); issue_acc(3'd5, 4'd6);
        step(); idle();
        @(negedge clk);
        chk("midrst_busy_before", 32'(hif.busy_vec), 32'h20);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(hif.busy_vec), 32'd0);
        chk("midrst_wb", 32'(hif.acc_wb_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            @(negedge clk);
            chk($sformatf("midrst_nowb_%0d", k), 32'(hif.acc_wb_valid), 32'd0);
        end

        // Perf: 3 load-use stalls + 2 RAW stalls.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(); reader(3'd2); hif.ex_rd = 3'd2; hif.ex_reg_write = 1'b1; hif.ex_is_load = 1'b1;
            @(negedge clk);
            chk($sformatf("perf_lu_stall_%0d", k), 32'(hif.stall), 32'd1);
        end
        step(); issue_acc(3'd1, 4'd3);
        @(negedge clk);
        chk("perf_issue", 32'(hif.acc_issue), 32'd1);
        for (int k = 0; k < 2; k++) begin
            step(); reader(3'd1);
            @(negedge clk);
            chk($sformatf("perf_raw_stall_%0d", k), 32'(hif.stall), 32'd1);
        end
        step(); reader(3'd1);
        @(negedge clk);
        chk("perf_fwd_no_stall", 32'(hif.stall), 32'd0);
`ifdef HAZARD_PERF_EN
        chk("perf_stall_cnt", hif.perf_stall_cnt, 32'd5);
        chk("perf_lu_cnt", hif.perf_lu_cnt, 32'd3);
`else
        chk("perf_stall_cnt_off", hif.perf_stall_cnt, 32'd0);
        chk("perf_lu_cnt_off", hif.perf_lu_cnt, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
